// File: rtl/z88_kbd_pkg.sv
// z88_kbd_pkg: shared types and constants for the Z88 PS/2 keyboard slice.
//   - rx_state_t  : PS/2 receive FSM state
//   - PFX_* / CMD_*: scancode set 2 prefixes and keyboard command bytes
//   - KEY_*       : Z88 key matrix bit indices (bit = row*8 + column)
//   - map_entry_t : scancode lookup result {valid, idx[5:0]}
package z88_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_BRK      = 8'hF0;
    localparam logic [7:0] CMD_BAT_OK   = 8'hAA;
    localparam logic [7:0] CMD_BAT_FAIL = 8'hFC;
    localparam logic [7:0] CMD_OVF_LO   = 8'h00;
    localparam logic [7:0] CMD_OVF_HI   = 8'hFF;

    localparam logic [5:0] KEY_LSHIFT  = 6'd54;
    localparam logic [5:0] KEY_RSHIFT  = 6'd63;
    localparam logic [5:0] KEY_ENTER   = 6'd6;
    localparam logic [5:0] KEY_SPACE   = 6'd61;
    localparam logic [5:0] KEY_ESC     = 6'd47;
    localparam logic [5:0] KEY_UP      = 6'd62;
    localparam logic [5:0] KEY_DOWN    = 6'd58;
    localparam logic [5:0] KEY_LEFT    = 6'd59;
    localparam logic [5:0] KEY_RIGHT   = 6'd60;
    localparam logic [5:0] KEY_DIAMOND = 6'd52;
    localparam logic [5:0] KEY_SQUARE  = 6'd55;
    localparam logic [5:0] KEY_A       = 6'd43;
    localparam logic [5:0] KEY_Z       = 6'd42;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } map_entry_t;

    function automatic map_entry_t map_hit(input logic [5:0] idx);
        map_entry_t e;
        e.valid = 1'b1;
        e.idx   = idx;
        return e;
    endfunction

endpackage

// File: rtl/z88_kbd_map.sv
// z88_kbd_map: combinational scancode-set-2 to Z88 matrix lookup ROM.
// Ports:
//   ext   in  1 : keycode was preceded by $E0
//   code  in  8 : keycode byte
//   entry out 7 : {valid, idx}; valid=0 for unmapped codes
// Config macro: Z88_PS2_EXT_EN compiles the $E0 (extended) half of the table.
// Without it every extended lookup misses, so prefixed keycodes are dropped.
module z88_kbd_map
    import z88_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output map_entry_t entry
);

    always_comb begin
        // NOTE: default assignment first so no path leaves entry unassigned
        // (otherwise a latch is inferred).
        entry = '0;
        if (!ext) begin
            case (code)
                8'h1C:   entry = map_hit(KEY_A);
                8'h1A:   entry = map_hit(KEY_Z);
                8'h12:   entry = map_hit(KEY_LSHIFT);
                8'h59:   entry = map_hit(KEY_RSHIFT);
                8'h5A:   entry = map_hit(KEY_ENTER);
                8'h29:   entry = map_hit(KEY_SPACE);
                8'h76:   entry = map_hit(KEY_ESC);
                default: entry = '0;
            endcase
        end
`ifdef Z88_PS2_EXT_EN
        else begin
            // $E0 $12 / $E0 $59 (fake shifts) deliberately fall to default.
            case (code)
                8'h75:   entry = map_hit(KEY_UP);
                8'h72:   entry = map_hit(KEY_DOWN);
                8'h6B:   entry = map_hit(KEY_LEFT);
                8'h74:   entry = map_hit(KEY_RIGHT);
                8'h14:   entry = map_hit(KEY_DIAMOND);
                8'h11:   entry = map_hit(KEY_SQUARE);
                8'h5A:   entry = map_hit(KEY_ENTER);
                default: entry = '0;
            endcase
        end
`endif
    end

endmodule

// File: rtl/z88_ps2_kbd.sv
// z88_ps2_kbd: PS/2 keyboard receiver + scancode decoder producing the
// 64-bit Z88 key matrix read by Blink on IN $B2.
// Parameters:
//   FILT_LEN : equal samples needed before the filtered PS/2 clock changes
//   TIMEOUT  : mck cycles without a falling PS/2 clock mid-frame before abort
// Ports:
//   mck      in   1 : master clock (only clock)
//   rin_n    in   1 : asynchronous active-low reset
//   ps2_clk  in   1 : PS/2 clock (asynchronous)
//   ps2_dat  in   1 : PS/2 data (asynchronous)
//   kbmat    out 64 : key state, bit r*8+c = key on row ca[8+r], column D[c]
//   rx_err   out  1 : one-cycle pulse on parity/framing error or timeout
//   byte_stb out  1 : one-cycle pulse on a good byte
//   byte_out out  8 : last good byte
// Config macro: Z88_PS2_EXT_EN enables decoding of $E0-prefixed keys.
module z88_ps2_kbd
    import z88_kbd_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 19660
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        rx_err,
    output logic        byte_stb,
    output logic [7:0]  byte_out
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt, filt_d, strobe;
    logic [FW-1:0] filt_cnt;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          brk, ext;
    map_entry_t    entry;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Synchronisers, glitch filter and falling-edge strobe. The idle bus is
    // high, so these reset to 1 to avoid a false edge after reset.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage see the previous
            // cycle's value, which is what builds the shift chain.
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            if (clk_s == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                filt     <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
            filt_d <= filt;
            strobe <= filt_d & ~filt;
        end
    end

    // Receive FSM with timeout. A strobe is handled before the timeout
    // check, so a strobe arriving on the expiry cycle wins.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tmo_cnt  <= '0;
            rx_err   <= 1'b0;
            byte_stb <= 1'b0;
            byte_out <= '0;
        end else begin
            rx_err   <= 1'b0;
            byte_stb <= 1'b0;
            if (strobe) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {dat_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= dat_s;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Odd parity: data plus parity bit has an odd count of ones.
                        if (dat_s && (^{shift, par})) begin
                            byte_stb <= 1'b1;
                            byte_out <= shift;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    rx_err  <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

    z88_kbd_map u_map (
        .ext   (ext),
        .code  (byte_out),
        .entry (entry)
    );

    // Decoder. In the default build ext still latches $E0, but the map has
    // no extended half, so the following keycode is swallowed.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            // NOTE: the key matrix is plain flops, not RAM, so it is reset
            // like any other state; Blink must never see stale keys.
            kbmat <= '0;
            brk   <= 1'b0;
            ext   <= 1'b0;
        end else if (rx_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (byte_stb) begin
            if (byte_out == PFX_BRK) begin
                brk <= 1'b1;
            end else if (byte_out == PFX_EXT) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
                if (!brk && !ext &&
                    (byte_out == CMD_BAT_OK || byte_out == CMD_BAT_FAIL ||
                     byte_out == CMD_OVF_LO || byte_out == CMD_OVF_HI)) begin
                    kbmat <= '0;
                end else if (entry.valid) begin
                    kbmat[entry.idx] <= ~brk;
                end
            end
        end
    end

endmodule

// File: tb/tb_z88_ps2_kbd.sv
// tb_z88_ps2_kbd: directed self-checking bench for z88_ps2_kbd.
// Drives PS/2 device-to-host frames bit by bit and compares the key matrix
// and strobe/error pulse counts against hand-computed values. Builds with or
// without Z88_PS2_EXT_EN; extended-key expectations follow the macro.
module tb_z88_ps2_kbd;

    localparam int FILT_LEN = 8;
    localparam int TIMEOUT  = 400;
    localparam int HALF     = 20;   // PS/2 half bit period in mck cycles

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [63:0] kbmat;
    logic        rx_err;
    logic        byte_stb;
    logic [7:0]  byte_out;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    z88_ps2_kbd #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .mck      (mck),
        .rin_n    (rin_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .kbmat    (kbmat),
        .rx_err   (rx_err),
        .byte_stb (byte_stb),
        .byte_out (byte_out)
    );

    always #50 mck = ~mck;

    always @(negedge mck) begin
        if (byte_stb) begin
            stb_cnt++;
            last_byte = byte_out;
        end
        if (rx_err) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mck);
        #1;
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop).
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic test_reset;
        rin_n = 1'b0;
        tick(3);
        rin_n = 1'b1;
        tick(3);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL reset_kbmat got=%h want=%h", kbmat, 64'd0); end
        total++; if (rx_err !== 1'b0) begin bad++; $display("FAIL reset_rx_err got=%b want=0", rx_err); end
        total++; if (byte_stb !== 1'b0) begin bad++; $display("FAIL reset_byte_stb got=%b want=0", byte_stb); end
        total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte_out got=%h want=00", byte_out); end
    endtask

    task automatic test_make_break;
        int s0;
        s0 = stb_cnt;
        send_byte(8'h1C);
        total++; if (stb_cnt !== s0 + 1) begin bad++; $display("FAIL mk_stb got=%0d want=%0d", stb_cnt, s0 + 1); end
        total++; if (last_byte !== 8'h1C) begin bad++; $display("FAIL mk_byte got=%h want=1c", last_byte); end
        total++; if (kbmat !== (64'd1 << 43)) begin bad++; $display("FAIL mk_a got=%h want=%h", kbmat, 64'd1 << 43); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (stb_cnt !== s0 + 3) begin bad++; $display("FAIL brk_stb got=%0d want=%0d", stb_cnt, s0 + 3); end
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL brk_a got=%h want=0", kbmat); end
    endtask

    task automatic test_multi_key;
        logic [63:0] exp;
        exp = (64'd1 << 54) | (64'd1 << 42);
        send_byte(8'h12);
        send_byte(8'h1A);
        total++; if (kbmat !== exp) begin bad++; $display("FAIL multi got=%h want=%h", kbmat, exp); end
        send_byte(8'h1A);  // auto-repeat
        total++; if (kbmat !== exp) begin bad++; $display("FAIL repeat got=%h want=%h", kbmat, exp); end
        send_byte(8'hAA);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL clr_aa got=%h want=0", kbmat); end
        send_byte(8'h12);
        send_byte(8'h00);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL clr_00 got=%h want=0", kbmat); end
        send_byte(8'h29);
        send_byte(8'hFF);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL clr_ff got=%h want=0", kbmat); end
        // $F0 $AA is a break of an unmapped code, not a clear
        send_byte(8'h29);
        send_byte(8'hF0);
        send_byte(8'hAA);
        total++; if (kbmat !== (64'd1 << 61)) begin bad++; $display("FAIL f0_aa got=%h want=%h", kbmat, 64'd1 << 61); end
        send_byte(8'hF0);
        send_byte(8'h29);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL brk_sp got=%h want=0", kbmat); end
    endtask

    task automatic test_parity_error;
        int s0, e0;
        send_byte(8'h29);
        s0 = stb_cnt;
        e0 = err_cnt;
        send_byte(8'hF0);
        send_bits(8'h1C, 1'b1, 11);
        total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL par_err got=%0d want=%0d", err_cnt, e0 + 1); end
        total++; if (stb_cnt !== s0 + 1) begin bad++; $display("FAIL par_stb got=%0d want=%0d", stb_cnt, s0 + 1); end
        total++; if (kbmat !== (64'd1 << 61)) begin bad++; $display("FAIL par_kbmat got=%h want=%h", kbmat, 64'd1 << 61); end
        // brk was cleared by the error, so $29 is a make (stays set)
        send_byte(8'h29);
        total++; if (kbmat !== (64'd1 << 61)) begin bad++; $display("FAIL par_flag got=%h want=%h", kbmat, 64'd1 << 61); end
        send_byte(8'h1C);
        total++; if (kbmat !== ((64'd1 << 61) | (64'd1 << 43))) begin bad++; $display("FAIL par_next got=%h want=%h", kbmat, (64'd1 << 61) | (64'd1 << 43)); end
        send_byte(8'hAA);
    endtask

    task automatic test_timeout;
        int e0, s0;
        e0 = err_cnt;
        s0 = stb_cnt;
        send_bits(8'h00, 1'b0, 5);   // start + 4 data bits
        tick(TIMEOUT + 100);
        total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL tmo_err got=%0d want=%0d", err_cnt, e0 + 1); end
        total++; if (stb_cnt !== s0) begin bad++; $display("FAIL tmo_stb got=%0d want=%0d", stb_cnt, s0); end
        send_byte(8'h29);
        total++; if (kbmat !== (64'd1 << 61)) begin bad++; $display("FAIL tmo_next got=%h want=%h", kbmat, 64'd1 << 61); end
        total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL tmo_extra got=%0d want=%0d", err_cnt, e0 + 1); end
        send_byte(8'hAA);
    endtask

    task automatic test_ext;
        logic [63:0] exp;
        send_byte(8'hE0);
        send_byte(8'h75);
`ifdef Z88_PS2_EXT_EN
        exp = 64'd1 << 62;
`else
        exp = 64'd0;
`endif
        total++; if (kbmat !== exp) begin bad++; $display("FAIL ext_up got=%h want=%h", kbmat, exp); end
        send_byte(8'hE0);
        send_byte(8'h5A);
`ifdef Z88_PS2_EXT_EN
        exp = exp | (64'd1 << 6);
`endif
        total++; if (kbmat !== exp) begin bad++; $display("FAIL ext_kpent got=%h want=%h", kbmat, exp); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
`ifdef Z88_PS2_EXT_EN
        exp = exp & ~(64'd1 << 62);
`endif
        total++; if (kbmat !== exp) begin bad++; $display("FAIL ext_brk got=%h want=%h", kbmat, exp); end
        send_byte(8'hE0);
        send_byte(8'h12);  // fake shift
        total++; if (kbmat !== exp) begin bad++; $display("FAIL ext_fake got=%h want=%h", kbmat, exp); end
        send_byte(8'h1C);
        exp = exp | (64'd1 << 43);
        total++; if (kbmat !== exp) begin bad++; $display("FAIL ext_after got=%h want=%h", kbmat, exp); end
        send_byte(8'hAA);
    endtask

    task automatic test_glitch;
        int s0, e0;
        s0 = stb_cnt;
        e0 = err_cnt;
        // Short low pulse with data low: would look like a start bit if it
        // got through the filter, then time out.
        ps2_dat = 1'b0;
        tick(2);
        ps2_clk = 1'b0;
        tick(FILT_LEN - 3);
        ps2_clk = 1'b1;
        tick(2);
        ps2_dat = 1'b1;
        tick(TIMEOUT + 50);
        total++; if (stb_cnt !== s0) begin bad++; $display("FAIL glitch_stb got=%0d want=%0d", stb_cnt, s0); end
        total++; if (err_cnt !== e0) begin bad++; $display("FAIL glitch_err got=%0d want=%0d", err_cnt, e0); end
        send_byte(8'h1A);
        total++; if (kbmat !== (64'd1 << 42)) begin bad++; $display("FAIL glitch_next got=%h want=%h", kbmat, 64'd1 << 42); end
    endtask

    task automatic test_reset_mid;
        int e0;
        send_bits(8'h29, 1'b0, 6);
        rin_n = 1'b0;
        tick(2);
        total++; if (kbmat !== 64'd0) begin bad++; $display("FAIL rmid_kbmat got=%h want=0", kbmat); end
        total++; if ({rx_err, byte_stb, byte_out} !== 10'd0) begin bad++; $display("FAIL rmid_out got=%b%b%h want=0", rx_err, byte_stb, byte_out); end
        rin_n = 1'b1;
        tick(5);
        e0 = err_cnt;
        send_byte(8'h29);
        total++; if (kbmat !== (64'd1 << 61)) begin bad++; $display("FAIL rmid_next got=%h want=%h", kbmat, 64'd1 << 61); end
        total++; if (err_cnt !== e0) begin bad++; $display("FAIL rmid_err got=%0d want=%0d", err_cnt, e0); end
    endtask

    initial begin
        test_reset;
        test_make_break;
        test_multi_key;
        test_parity_error;
        test_timeout;
        test_ext;
        test_glitch;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
